// File: rtl/div_restoring_seq.sv
// Sequential restoring divider: one quotient bit per RUN cycle, MSB first.
// Optional macro DIV_SIGNED_EN selects two's-complement operands with sign correction.
module div_restoring_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned RW    = WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [RW-1:0]    rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;
`ifdef DIV_SIGNED_EN
    logic             neg_quo_q;
    logic             neg_rem_q;
`endif

    logic [RW-1:0]    part_rem;
    logic [RW:0]      trial;
    logic [RW-1:0]    rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] res_quo;
    logic [WIDTH-1:0] res_rem;
    logic             last_iter;

    // Shift in the next dividend bit, trial-subtract, restore on borrow
    always_comb begin
        part_rem = RW'({rem_q, quo_q[WIDTH-1]});
        trial    = {1'b0, part_rem} - {2'b00, dvs_q};
        if (trial[RW]) begin
            rem_d = part_rem;
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_d = trial[RW-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Operand magnitudes at capture and sign-corrected results at completion
    always_comb begin
`ifdef DIV_SIGNED_EN
        mag_a   = dividend[WIDTH-1] ? (~dividend) + WIDTH'(1) : dividend;
        mag_b   = divisor[WIDTH-1]  ? (~divisor)  + WIDTH'(1) : divisor;
        res_quo = neg_quo_q ? (~quo_d) + WIDTH'(1) : quo_d;
        res_rem = neg_rem_q ? (~rem_d[WIDTH-1:0]) + WIDTH'(1) : rem_d[WIDTH-1:0];
`else
        mag_a   = dividend;
        mag_b   = divisor;
        res_quo = quo_d;
        res_rem = rem_d[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (divisor == '0) begin
                            // Divide-by-zero bypasses RUN: result is fixed, not iterated
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            rem_q   <= '0;
                            quo_q   <= mag_a;
                            dvs_q   <= mag_b;
                            cnt_q   <= '0;
`ifdef DIV_SIGNED_EN
                            neg_quo_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            neg_rem_q <= dividend[WIDTH-1];
`endif
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        quotient_q  <= res_quo;
                        remainder_q <= res_rem;
                        dbz_q       <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_restoring_seq.sv
// Scoreboard bench for div_restoring_seq; expected results and done edges queued at acceptance.
// Define DIV_SIGNED_EN for both bench and RTL to exercise signed mode.
module tb_div_restoring_seq;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   ncyc     = 0;

    logic [W-1:0] last_q;
    logic [W-1:0] last_r;
    logic         last_z;
    logic         prev_done;

    div_restoring_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, expv, ncyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
`ifdef DIV_SIGNED_EN
        int ia;
        int ib;
`endif
        e.due = 0;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            ia  = int'($signed(a));
            ib  = int'($signed(b));
            e.q = W'(ia / ib);
            e.r = W'(ia % ib);
`else
            e.q = a / b;
            e.r = a % b;
`endif
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Called #1 after the accepting edge; done is due W+1 (or 1) negedges later
    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e     = model(a, b);
        e.due = ncyc + ((b == '0) ? 1 : int'(W) + 1);
        sb.push_back(e);
    endtask

    // Monitor: compare on done, otherwise require held results
    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            last_q    = '0;
            last_r    = '0;
            last_z    = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                check("done_width", 32'(prev_done), 32'd0);
                check("busy_at_done", 32'(busy), 32'd1);
                if (sb.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("latency", 32'(ncyc), 32'(e.due));
                    check("quotient", 32'(quotient), 32'(e.q));
                    check("remainder", 32'(remainder), 32'(e.r));
                    check("div_by_zero", 32'(div_by_zero), 32'(e.z));
                end
                last_q = quotient;
                last_r = remainder;
                last_z = div_by_zero;
            end else begin
                check("hold_q", 32'(quotient), 32'(last_q));
                check("hold_r", 32'(remainder), 32'(last_r));
                check("hold_z", 32'(div_by_zero), 32'(last_z));
            end
            prev_done = done;
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (!busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", 32'(ok), 32'd1);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        push_exp(a, b);
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        int           dn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_z", 32'(div_by_zero), 32'd0);
        repeat (2) @(posedge clk);

        // Start presented on the first edge after reset release: 13/3
        @(negedge clk);
        rst_n    = 1'b1;
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd3;
        @(posedge clk);
        #1;
        push_exp(4'd13, 4'd3);
        start = 1'b0;
        wait_idle();

        do_op(4'd9, 4'd0);
        do_op(4'd8, 4'd2);

        // Start re-pulsed while busy must be ignored
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd15;
        divisor  = 4'd4;
        @(posedge clk);
        #1;
        push_exp(4'd15, 4'd4);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd1;
        divisor  = 4'd1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset mid-RUN abandons the division
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_q", 32'(quotient), 32'd0);
        check("mid_rst_r", 32'(remainder), 32'd0);
        check("mid_rst_z", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            dn += int'(done);
        end
        check("no_done_after_rst", 32'(dn), 32'd0);

        do_op(4'b1001, 4'b0010);
        do_op(4'b1000, 4'b1111);
        do_op(4'd15, 4'd1);
        do_op(4'd2, 4'd7);

        // Start held high: accepted every W+2 edges, operands changed after each accept
        @(negedge clk);
        a        = 4'd11;
        b        = 4'd2;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            push_exp(a, b);
            a = W'($urandom_range(0, 15));
            b = W'($urandom_range(1, 15));
            if (i == 3) begin
                start = 1'b0;
            end else begin
                dividend = a;
                divisor  = b;
                repeat (W + 1) @(posedge clk);
            end
        end
        wait_idle();

        for (int i = 0; i < 16; i++) begin
            a = W'($urandom_range(0, 15));
            b = (i % 5 == 0) ? '0 : W'($urandom_range(0, 15));
            do_op(a, b);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1, "global timeout");
    end

endmodule
